// File: rtl/multicycle_control.sv
// Multicycle ARM control unit.
// A 10-state FSM sequences each instruction and drives the datapath controls for
// the current state. It keeps its own NZCV register, which is updated from the
// ALU flags at the end of EXECR/EXECI. Every instruction is gated by a full ARM
// condition check against that register.
module multicycle_control #(
    parameter bit         SUPPORT_CMP        = 1'b1,
    parameter bit         SUPPORT_NEG_OFFSET = 1'b1,
    parameter logic [3:0] FLAGS_RESET        = 4'b0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemW,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic        RegW,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  flags;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic        imm;
    logic [3:0]  cmd;
    logic        s_bit;
    logic        up;

    logic        cond_ex;
    logic [1:0]  dp_control;
    logic        no_write;
    logic [1:0]  flag_w;

    logic        pc_write_raw;
    logic        mem_w_raw;
    logic        ir_write_raw;
    logic        reg_w_raw;

    // The offset and register fields are consumed by the datapath, not by this unit.
    logic        unused_instr;
    assign unused_instr = ^Instr[19:0];

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign imm   = Instr[25];
    assign cmd   = Instr[24:21];
    assign s_bit = Instr[20];
    assign up    = Instr[23];

    assign ImmSrc = op;
    assign RegSrc = {(op == 2'b01), (op == 2'b10)};
    assign Flags  = flags;
    assign State  = state;

    // Evaluate the instruction condition field against the stored NZCV flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing decode. Unknown commands do nothing: they add, never write
    // a register and never touch the flags.
    // CMP and CMN always update the flags, whatever S says.
    always_comb begin
        dp_control = 2'b00;
        no_write   = 1'b1;
        flag_w     = 2'b00;
        case (cmd)
            4'b0100: begin
                dp_control = 2'b00;
                no_write   = 1'b0;
                flag_w     = {s_bit, s_bit};
            end
            4'b0010: begin
                dp_control = 2'b01;
                no_write   = 1'b0;
                flag_w     = {s_bit, s_bit};
            end
            4'b0000: begin
                dp_control = 2'b10;
                no_write   = 1'b0;
                flag_w     = {s_bit, 1'b0};
            end
            4'b1100: begin
                dp_control = 2'b11;
                no_write   = 1'b0;
                flag_w     = {s_bit, 1'b0};
            end
            4'b1010: begin
                if (SUPPORT_CMP) begin
                    dp_control = 2'b01;
                    flag_w     = 2'b11;
                end
            end
            4'b1011: begin
                if (SUPPORT_CMP) begin
                    dp_control = 2'b00;
                    flag_w     = 2'b11;
                end
            end
            default: begin
                dp_control = 2'b00;
                no_write   = 1'b1;
                flag_w     = 2'b00;
            end
        endcase
    end

    // Next-state logic for the instruction sequencer.
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   next_state = MEMADR;
                    2'b00:   next_state = imm ? EXECI : EXECR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: next_state = s_bit ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
            default: next_state = FETCH;
        endcase
    end

    // State register and NZCV register. Flags only change at the end of an
    // execute state whose condition passed.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= FETCH;
            flags <= FLAGS_RESET;
        end else begin
            state <= next_state;
            if (((state == EXECR) || (state == EXECI)) && cond_ex) begin
                if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
                if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Per-state control outputs, decoded from the current state.
    always_comb begin
        pc_write_raw = 1'b0;
        AdrSrc       = 1'b0;
        mem_w_raw    = 1'b0;
        ir_write_raw = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        reg_w_raw    = 1'b0;
        ALUControl   = 2'b00;
        case (state)
            FETCH: begin
                AdrSrc       = 1'b0;
                ir_write_raw = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_write_raw = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = (SUPPORT_NEG_OFFSET && !up) ? 2'b01 : 2'b00;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w_raw = cond_ex;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                mem_w_raw = cond_ex;
            end
            EXECR: begin
                ALUSrcB    = 2'b00;
                ALUControl = dp_control;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_control;
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                reg_w_raw = cond_ex & ~no_write;
            end
            BRANCH: begin
                ALUSrcB      = 2'b01;
                ResultSrc    = 2'b10;
                pc_write_raw = cond_ex;
            end
            default: begin
                pc_write_raw = 1'b0;
            end
        endcase
    end

    // Architectural write enables are held off for as long as reset is high,
    // including when reset arrives partway through an instruction.
    assign PCWrite = pc_write_raw & ~Reset;
    assign IRWrite = ir_write_raw & ~Reset;
    assign MemW    = mem_w_raw    & ~Reset;
    assign RegW    = reg_w_raw    & ~Reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

    logic        CLK;
    logic        Reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemW;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic        RegW;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  Flags;
    logic [3:0]  State;

    int compareCount  = 0;
    int mismatchCount = 0;

    multicycle_control dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemW       (MemW),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegW       (RegW),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Flags      (Flags),
        .State      (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instrValue, input logic [3:0] aluFlagsValue);
        Instr    = instrValue;
        ALUFlags = aluFlagsValue;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        Reset    = 1'b1;
        Instr    = 32'hE5921004;
        ALUFlags = 4'b0000;

        // Reset held for two cycles.
        nextCycle();
        nextCycle();
        checkOutput("rst_state",   32'(State),   32'd0);
        checkOutput("rst_flags",   32'(Flags),   32'h0);
        checkOutput("rst_pcwrite", 32'(PCWrite), 32'd0);
        checkOutput("rst_irwrite", 32'(IRWrite), 32'd0);

        // Release reset: FETCH drives its outputs immediately.
        Reset = 1'b0;
        #1;
        checkOutput("fetch_pcwrite",   32'(PCWrite),   32'd1);
        checkOutput("fetch_irwrite",   32'(IRWrite),   32'd1);
        checkOutput("fetch_alusrcb",   32'(ALUSrcB),   32'd2);
        checkOutput("fetch_resultsrc", 32'(ResultSrc), 32'd2);
        checkOutput("fetch_alusrca",   32'(ALUSrcA),   32'd1);

        // LDR R1,[R2,#4]
        nextCycle();
        checkOutput("ldr_decode", 32'(State), 32'd1);
        checkOutput("ldr_immsrc", 32'(ImmSrc), 32'd1);
        checkOutput("ldr_regsrc", 32'(RegSrc), 32'd2);
        nextCycle();
        checkOutput("ldr_memadr",   32'(State),      32'd2);
        checkOutput("ldr_alusrcb",  32'(ALUSrcB),    32'd1);
        checkOutput("ldr_aluctl",   32'(ALUControl), 32'd0);
        checkOutput("ldr_alusrca",  32'(ALUSrcA),    32'd0);
        nextCycle();
        checkOutput("ldr_memrd",    32'(State),  32'd3);
        checkOutput("ldr_adrsrc",   32'(AdrSrc), 32'd1);
        nextCycle();
        checkOutput("ldr_memwb",    32'(State),     32'd4);
        checkOutput("ldr_resultsrc",32'(ResultSrc), 32'd1);
        checkOutput("ldr_regw",     32'(RegW),      32'd1);
        nextCycle();
        checkOutput("ldr_done", 32'(State), 32'd0);

        // STR R1,[R2,#-8]
        applyStimulus(32'hE5021008, 4'b0000);
        nextCycle();
        checkOutput("str_decode", 32'(State), 32'd1);
        nextCycle();
        checkOutput("str_memadr", 32'(State),      32'd2);
        checkOutput("str_aluctl", 32'(ALUControl), 32'd1);
        nextCycle();
        checkOutput("str_memwr",  32'(State),  32'd5);
        checkOutput("str_memw",   32'(MemW),   32'd1);
        checkOutput("str_adrsrc", 32'(AdrSrc), 32'd1);
        checkOutput("str_regw",   32'(RegW),   32'd0);
        nextCycle();
        checkOutput("str_done", 32'(State), 32'd0);

        // SUBS R1,R1,#0 with a zero ALU result
        applyStimulus(32'hE2511000, 4'b0000);
        nextCycle();
        nextCycle();
        checkOutput("subs_execi", 32'(State), 32'd7);
        applyStimulus(32'hE2511000, 4'b0100);
        checkOutput("subs_aluctl",  32'(ALUControl), 32'd1);
        checkOutput("subs_alusrcb", 32'(ALUSrcB),    32'd1);
        nextCycle();
        applyStimulus(32'hE2511000, 4'b0000);
        checkOutput("subs_aluwb", 32'(State), 32'd8);
        checkOutput("subs_flags", 32'(Flags), 32'h4);
        checkOutput("subs_regw",  32'(RegW),  32'd1);
        nextCycle();

        // BLE taken (Z=1)
        applyStimulus(32'hDA000000, 4'b0000);
        nextCycle();
        nextCycle();
        checkOutput("ble_branch",  32'(State),   32'd9);
        checkOutput("ble_pcwrite", 32'(PCWrite), 32'd1);
        checkOutput("ble_alusrcb", 32'(ALUSrcB), 32'd1);
        nextCycle();
        checkOutput("ble_done", 32'(State), 32'd0);

        // Clear flags with a one-cycle reset, then BLE not taken
        Reset = 1'b1;
        nextCycle();
        Reset = 1'b0;
        #1;
        checkOutput("clr_flags", 32'(Flags), 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("blen_branch",  32'(State),   32'd9);
        checkOutput("blen_pcwrite", 32'(PCWrite), 32'd0);
        nextCycle();

        // CMP R1,#0 with a negative result
        applyStimulus(32'hE3510000, 4'b0000);
        nextCycle();
        nextCycle();
        applyStimulus(32'hE3510000, 4'b1000);
        checkOutput("cmp_execi",  32'(State),      32'd7);
        checkOutput("cmp_aluctl", 32'(ALUControl), 32'd1);
        nextCycle();
        applyStimulus(32'hE3510000, 4'b0000);
        checkOutput("cmp_flags", 32'(Flags), 32'h8);
        checkOutput("cmp_regw",  32'(RegW),  32'd0);
        nextCycle();

        // ADDGES (N=1,V=0, so GE fails): no flag update, no register write
        applyStimulus(32'hA0912003, 4'b0000);
        nextCycle();
        nextCycle();
        applyStimulus(32'hA0912003, 4'b0110);
        checkOutput("addge_execr",   32'(State),      32'd6);
        checkOutput("addge_alusrcb", 32'(ALUSrcB),    32'd0);
        checkOutput("addge_aluctl",  32'(ALUControl), 32'd0);
        nextCycle();
        applyStimulus(32'hA0912003, 4'b0000);
        checkOutput("addge_flags", 32'(Flags), 32'h8);
        checkOutput("addge_regw",  32'(RegW),  32'd0);
        nextCycle();

        // ORR register form
        applyStimulus(32'hE1812003, 4'b0000);
        nextCycle();
        nextCycle();
        checkOutput("orr_aluctl", 32'(ALUControl), 32'd3);
        nextCycle();
        checkOutput("orr_regw", 32'(RegW), 32'd1);
        nextCycle();

        // Op = 11 goes straight back to FETCH
        applyStimulus(32'hEC000000, 4'b0000);
        nextCycle();
        checkOutput("op11_decode", 32'(State), 32'd1);
        nextCycle();
        checkOutput("op11_fetch", 32'(State), 32'd0);

        // Reset in the middle of STR
        applyStimulus(32'hE5820000, 4'b0000);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("rststr_memwr", 32'(State), 32'd5);
        checkOutput("rststr_memw_pre", 32'(MemW), 32'd1);
        Reset = 1'b1;
        #1;
        checkOutput("rststr_memw", 32'(MemW), 32'd0);
        nextCycle();
        checkOutput("rststr_state", 32'(State), 32'd0);
        checkOutput("rststr_flags", 32'(Flags), 32'h0);
        Reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the multicycle ARM datapath; replaces the single-cycle combinational decoder.
- Sequences each instruction through a 10-state FSM and drives the control signals for that state (PC/IR write, memory address source, ALU operand muxes, register/memory write).
- Adds what the single-cycle decoder lacks: full ARM condition evaluation against an internal NZCV flags register, CMP/CMN, and down-offset (U=0) LDR/STR.
- Sits between the instruction register (Instr) and the datapath; takes ALUFlags back from the ALU.

Parameters:
SUPPORT_CMP, 1, 1: decode cmd 1010 (CMP) and 1011 (CMN) as flag-only ops; 0: treat them as unsupported.
SUPPORT_NEG_OFFSET, 1, 1: honour Instr[23] (U) for LDR/STR address; 0: always add offset.
FLAGS_RESET, 4'b0000, reset value of NZCV register.

Ports:
CLK  input  1  clock; all state changes on rising edge.
Reset  input  1  synchronous, active-high reset.
Instr  input  32  current instruction from the IR.
ALUFlags  input  4  NZCV from the ALU, valid in the current cycle.
PCWrite  output  1  PC register enable.
AdrSrc  output  1  memory address mux: 0 = PC, 1 = ALUOut.
MemW  output  1  data memory write enable.
IRWrite  output  1  instruction register enable.
ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
ALUSrcA  output  1  0 = RD1, 1 = PC.
ALUSrcB  output  2  00 = RD2, 01 = ExtImm, 10 = constant 4.
ImmSrc  output  2  equals Instr[27:26] in every state.
RegW  output  1  register file write enable.
RegSrc  output  2  RegSrc[0] = (Op==10); RegSrc[1] = (Op==01).
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
Flags  output  4  current NZCV register contents.
State  output  4  current FSM state encoding, for debug.

Behaviour:
- Fields: Op = Instr[27:26], I = Instr[25], cmd = Instr[24:21], S = Instr[20], L = Instr[20], U = Instr[23], Cond = Instr[31:28].
- State encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9.
- Reset:
  - On the next edge: State <= FETCH and Flags <= FLAGS_RESET.
  - While Reset = 1, PCWrite, IRWrite, MemW and RegW are forced to 0 (this includes reset asserted mid-instruction).
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR if Op = 01; EXECI if Op = 00 and I = 1; EXECR if Op = 00 and I = 0; BRANCH if Op = 10; FETCH if Op = 11.
  - MEMADR -> MEMRD if L = 1, else MEMWR.
  - MEMRD -> MEMWB.
  - EXECR / EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
  - Undefined encodings 10..15 -> FETCH.
- Latency in cycles: LDR 5, STR 4, data-processing 4, B 3, Op = 11 2.
- Outputs per state (anything not listed is 0 / 00):
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 1, ALUSrcB = 10, ALUControl = 00, ResultSrc = 10, PCWrite = 1.
  - DECODE: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 00, ResultSrc = 10.
  - MEMADR: ALUSrcA = 0, ALUSrcB = 01. ALUControl = 01 if SUPPORT_NEG_OFFSET and U = 0, else 00.
  - MEMRD: AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegW = CondEx.
  - MEMWR: AdrSrc = 1, MemW = CondEx.
  - EXECR: ALUSrcA = 0, ALUSrcB = 00, ALUControl from the ALU decode.
  - EXECI: ALUSrcA = 0, ALUSrcB = 01, ALUControl from the ALU decode.
  - ALUWB: ResultSrc = 00, RegW = CondEx & ~NoWrite.
  - BRANCH: ALUSrcA = 0, ALUSrcB = 01, ALUControl = 00, ResultSrc = 10, PCWrite = CondEx.
- ALU decode:
  - cmd 0100 -> 00 (ADD); 0010 -> 01 (SUB); 0000 -> 10 (AND); 1100 -> 11 (ORR).
  - 1010 -> 01 with NoWrite = 1 (CMP); 1011 -> 00 with NoWrite = 1 (CMN). Both only when SUPPORT_CMP = 1.
  - Any other cmd: ALUControl = 00, NoWrite = 1, FlagW = 00.
  - FlagW[1] (NZ) = S, forced to 1 for CMP/CMN.
  - FlagW[0] (CV) = FlagW[1] & (cmd is ADD, SUB, CMP or CMN).
- Flags update:
  - Only at the end of EXECR/EXECI, and only when CondEx = 1.
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1].
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0].
  - Flags are never written in any other state.
- CondEx is combinational from Cond and the current Flags (N, Z, C, V):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 -> 0.
- Instr is stable from DECODE until the return to FETCH, because IR is written only in FETCH.

Test Plan:
- Reset = 1 for 2 cycles, then release -> State = 0, Flags = 0000, and PCWrite = IRWrite = 0 while Reset is high. First cycle after release: PCWrite = 1, IRWrite = 1, ALUSrcB = 10, ResultSrc = 10.
- Instr = E5921004 (LDR R1,[R2,#4]) -> states 0,1,2,3,4; MEMADR: ALUSrcB = 01, ALUControl = 00; MEMRD: AdrSrc = 1; MEMWB: ResultSrc = 01, RegW = 1; then State = 0.
- Instr = E5021008 (STR R1,[R2,#-8]) -> states 0,1,2,5; MEMADR: ALUControl = 01; MEMWR: MemW = 1, AdrSrc = 1, RegW = 0.
- Instr = E2511000 (SUBS) with ALUFlags = 0100 in EXECI -> Flags = 0100 after that cycle. Then DA000000 (BLE) -> states 0,1,9 with PCWrite = 1 in BRANCH.
- Flags = 0000, Instr = DA000000 -> PCWrite = 0 in BRANCH. Instr = E3510000 (CMP) with ALUFlags = 1000 -> ALUControl = 01, Flags = 1000, RegW = 0 in ALUWB.
- Reset asserted during MEMWR of E5820000 -> MemW = 0 that cycle; State = 0 and Flags = 0000 after the edge.
